// File: rtl/group_update_sequencer.sv
// Colour-group sweep sequencer for the p-bit update-order LUT.
// Holds each group for a fixed time, then hands off a snapshot.
module group_update_sequencer #(
   parameter int NUM_GROUPS  = 4,
   parameter int GROUP_W     = 3,
   parameter int HOLD_CYCLES = 4,
   parameter int SWEEP_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [SWEEP_W-1:0] num_sweeps,
   output logic [0:GROUP_W-1] group_EN,
   output logic               group_valid,
   output logic               snap_req,
   input  logic               snap_ack,
   output logic [SWEEP_W-1:0] sweep_count,
   output logic               busy,
   output logic               done
);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0]      LAST_H = HW'(HOLD_CYCLES - 1);
   localparam logic [GROUP_W-1:0] LAST_G = GROUP_W'(NUM_GROUPS - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_UPDATE = 2'd1;
   localparam logic [1:0] S_SNAP   = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]         r_state;
   logic [HW-1:0]      r_hold;
   logic [0:GROUP_W-1] r_group;
   logic               r_valid;
   logic               r_snap;
   logic [SWEEP_W-1:0] r_count;
   logic [SWEEP_W-1:0] r_num;
   logic               r_stop;
   logic               r_busy;
   logic               r_done;

   logic w_last_hold;
   logic w_last_group;
   logic w_run_done;

   assign w_last_hold  = (r_hold == LAST_H);
   assign w_last_group = (r_group == LAST_G);
   // A stop arriving with the ack still ends the run at this boundary
   assign w_run_done   = ((r_num != '0) && (r_count == r_num))
                         || r_stop || stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_hold  <= '0;
         r_group <= '0;
         r_valid <= 1'b0;
         r_snap  <= 1'b0;
         r_count <= '0;
         r_num   <= '0;
         r_stop  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (r_state != S_IDLE && stop) begin
            r_stop <= 1'b1;
         end
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_num   <= num_sweeps;
                  r_count <= '0;
                  r_stop  <= 1'b0;
                  r_hold  <= '0;
                  r_group <= '0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               if (w_last_hold) begin
                  r_hold <= '0;
                  if (w_last_group) begin
                     r_count <= r_count + SWEEP_W'(1);
                     r_valid <= 1'b0;
                     r_snap  <= 1'b1;
                     r_state <= S_SNAP;
                  end else begin
                     r_group <= r_group + GROUP_W'(1);
                  end
               end else begin
                  r_hold <= r_hold + HW'(1);
               end
            end
            S_SNAP: begin
               if (snap_ack) begin
                  r_snap <= 1'b0;
                  r_hold <= '0;
                  r_group <= '0;
                  if (w_run_done) begin
                     r_done  <= 1'b1;
                     r_state <= S_FINISH;
                  end else begin
                     r_valid <= 1'b1;
                     r_state <= S_UPDATE;
                  end
               end
            end
            S_FINISH: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign group_EN    = r_group;
   assign group_valid = r_valid;
   assign snap_req    = r_snap;
   assign sweep_count = r_count;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule
